// File: rtl/mem_stage_pkg.sv
// Shared opcode/funct3 constants and decode helpers for the MEM stage.
package mem_stage_pkg;
`include "instructions.sv"
`include "mem_operations.sv"

    localparam logic [6:0] OPC_LOAD  = `LOAD;
    localparam logic [6:0] OPC_STORE = `STORE;

    localparam logic [2:0] F3_LB  = `LB;
    localparam logic [2:0] F3_LH  = `LH;
    localparam logic [2:0] F3_LW  = `LW;
    localparam logic [2:0] F3_LBU = `LBU;
    localparam logic [2:0] F3_LHU = `LHU;
    localparam logic [2:0] F3_SB  = `SB;
    localparam logic [2:0] F3_SH  = `SH;
    localparam logic [2:0] F3_SW  = `SW;

    function automatic logic funct3_ok(input logic is_store, input logic [2:0] f3);
        if (is_store)
            return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
        return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
               (f3 == F3_LBU) || (f3 == F3_LHU);
    endfunction

    // funct3[1:0] encodes access size identically for loads and stores
    function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] a);
        return ((f3[1:0] == 2'b01) && a[0]) || ((f3[1:0] == 2'b10) && (a != 2'b00));
    endfunction
endpackage

// File: rtl/instructions.sv
// RV32I major opcodes used by the pipeline stages.
`ifndef INSTRUCTIONS_SV
`define INSTRUCTIONS_SV
`define LOAD  7'b0000011
`define STORE 7'b0100011
`endif

// File: rtl/mem_operations.sv
// RV32I load/store funct3 codes.
`ifndef MEM_OPERATIONS_SV
`define MEM_OPERATIONS_SV
`define LB  3'b000
`define LH  3'b001
`define LW  3'b010
`define LBU 3'b100
`define LHU 3'b101
`define SB  3'b000
`define SH  3'b001
`define SW  3'b010
`endif

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane steering: store byte enables / replicated data, load extract + extend.
// Purely combinational, no backpressure.
module lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  addr,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data
);
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel  = rdata[{addr, 3'b000} +: 8];
        half_sel  = addr[1] ? rdata[31:16] : rdata[15:0];
        be        = 4'b0000;
        wdata     = rs2;
        load_data = '0;
        // Halfword lanes ignore addr[0], word lanes ignore addr[1:0]
        case (funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << addr;
                wdata = {4{rs2[7:0]}};
            end
            2'b01: begin
                be    = addr[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rs2[15:0]}};
            end
            2'b10:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        case (funct3)
            F3_LB:   load_data = {{24{byte_sel[7]}}, byte_sel};
            F3_LH:   load_data = {{16{half_sel[15]}}, half_sel};
            F3_LW:   load_data = rdata;
            F3_LBU:  load_data = {24'h0, byte_sel};
            F3_LHU:  load_data = {16'h0, half_sel};
            default: load_data = '0;
        endcase
    end
endmodule

// File: rtl/mem_stage.sv
// MEM stage: RV32I loads/stores over a single-outstanding req/gnt bus, pass-through otherwise.
// Latency: 1 cycle non-memory, 2 store, >=3 load. Optional MEM_MISALIGN_CHECK_EN traps misaligned.
// Backpressure: one instruction in flight; MEM_EX_get_o low until WB takes the result.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int BITSIZE = 32
) (
    input  logic               clk,
    input  logic               resetn_i,
    input  logic               EX_MEM_give_i,
    output logic               MEM_EX_get_o,
    input  logic [31:0]        EX_MEM_instruction_i,
    input  logic [BITSIZE-1:0] EX_MEM_d_i,
    input  logic [BITSIZE-1:0] EX_MEM_rs2_i,
    input  logic               WB_MEM_get_i,
    output logic               MEM_WB_give_o,
    output logic [31:0]        MEM_WB_instruction_o,
    output logic [BITSIZE-1:0] MEM_WB_d_o,
    output logic               MEM_WB_misaligned_o,
    output logic               mem_req_o,
    output logic               mem_we_o,
    output logic [BITSIZE-1:0] mem_addr_o,
    output logic [3:0]         mem_be_o,
    output logic [BITSIZE-1:0] mem_wdata_o,
    input  logic               mem_gnt_i,
    input  logic               mem_rvalid_i,
    input  logic [BITSIZE-1:0] mem_rdata_i
);
    if (BITSIZE != 32) begin : g_bitsize_check
        $error("mem_stage: only BITSIZE=32 is supported");
    end

    typedef enum logic [1:0] {S_GET_INSTR, S_REQ, S_WAIT, S_GIVE} state_t;

    state_t      state;
    logic [1:0]  addr_lo;
    logic [2:0]  sel_funct3;
    logic [1:0]  sel_addr;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;
    logic        ex_is_load, ex_is_store, ex_is_mem, ex_f3_ok, ex_misaligned;

    assign ex_is_load  = (EX_MEM_instruction_i[6:0] == OPC_LOAD);
    assign ex_is_store = (EX_MEM_instruction_i[6:0] == OPC_STORE);
    assign ex_is_mem   = ex_is_load || ex_is_store;
    assign ex_f3_ok    = funct3_ok(ex_is_store, EX_MEM_instruction_i[14:12]);
`ifdef MEM_MISALIGN_CHECK_EN
    assign ex_misaligned = is_misaligned(EX_MEM_instruction_i[14:12], EX_MEM_d_i[1:0]);
`else
    assign ex_misaligned = 1'b0;
`endif

    // Aligner sees the incoming instruction at accept, the latched one afterwards
    assign sel_funct3 = (state == S_GET_INSTR) ? EX_MEM_instruction_i[14:12] : MEM_WB_instruction_o[14:12];
    assign sel_addr   = (state == S_GET_INSTR) ? EX_MEM_d_i[1:0] : addr_lo;

    lsu_align u_lsu_align (
        .funct3    (sel_funct3),
        .addr      (sel_addr),
        .rs2       (EX_MEM_rs2_i),
        .rdata     (mem_rdata_i),
        .be        (lane_be),
        .wdata     (lane_wdata),
        .load_data (load_data)
    );

    always_ff @(posedge clk or negedge resetn_i) begin
        if (!resetn_i) begin
            state                <= S_GET_INSTR;
            addr_lo              <= 2'b00;
            MEM_EX_get_o         <= 1'b0;
            MEM_WB_give_o        <= 1'b0;
            MEM_WB_instruction_o <= '0;
            MEM_WB_d_o           <= '0;
            MEM_WB_misaligned_o  <= 1'b0;
            mem_req_o            <= 1'b0;
            mem_we_o             <= 1'b0;
            mem_addr_o           <= '0;
            mem_be_o             <= 4'b0000;
            mem_wdata_o          <= '0;
        end else begin
            case (state)
                S_GET_INSTR: begin
                    if (MEM_EX_get_o && EX_MEM_give_i) begin
                        MEM_EX_get_o         <= 1'b0;
                        MEM_WB_instruction_o <= EX_MEM_instruction_i;
                        addr_lo              <= EX_MEM_d_i[1:0];
                        if (ex_is_mem && ex_f3_ok && !ex_misaligned) begin
                            state       <= S_REQ;
                            mem_req_o   <= 1'b1;
                            mem_we_o    <= ex_is_store;
                            mem_addr_o  <= {EX_MEM_d_i[BITSIZE-1:2], 2'b00};
                            mem_be_o    <= lane_be;
                            mem_wdata_o <= lane_wdata;
                            MEM_WB_d_o  <= EX_MEM_d_i;
                        end else begin
                            // Invalid funct3 yields zero; a trapped access reports its address
                            state               <= S_GIVE;
                            MEM_WB_give_o       <= 1'b1;
                            MEM_WB_misaligned_o <= ex_is_mem && ex_f3_ok && ex_misaligned;
                            MEM_WB_d_o          <= (ex_is_mem && !ex_f3_ok) ? '0 : EX_MEM_d_i;
                        end
                    end else begin
                        MEM_EX_get_o <= 1'b1;
                    end
                end
                S_REQ: begin
                    if (mem_gnt_i) begin
                        mem_req_o <= 1'b0;
                        if (mem_we_o) begin
                            state         <= S_GIVE;
                            MEM_WB_give_o <= 1'b1;
                        end else begin
                            state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (mem_rvalid_i) begin
                        MEM_WB_d_o    <= load_data;
                        MEM_WB_give_o <= 1'b1;
                        state         <= S_GIVE;
                    end
                end
                S_GIVE: begin
                    if (WB_MEM_get_i) begin
                        MEM_WB_give_o       <= 1'b0;
                        MEM_WB_misaligned_o <= 1'b0;
                        MEM_EX_get_o        <= 1'b1;
                        state               <= S_GET_INSTR;
                    end
                end
                default: state <= S_GET_INSTR;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: bus responder, WB scoreboard monitor, stimulus driver.
module tb_mem_stage;
    logic        clk = 1'b0;
    logic        resetn_i;
    logic        EX_MEM_give_i, MEM_EX_get_o;
    logic [31:0] EX_MEM_instruction_i, EX_MEM_d_i, EX_MEM_rs2_i;
    logic        WB_MEM_get_i, MEM_WB_give_o;
    logic [31:0] MEM_WB_instruction_o, MEM_WB_d_o;
    logic        MEM_WB_misaligned_o;
    logic        mem_req_o, mem_we_o;
    logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata_i;
    logic [3:0]  mem_be_o;
    logic        mem_gnt_i, mem_rvalid_i;

    always #5 clk = ~clk;

    mem_stage #(.BITSIZE(32)) dut (
        .clk(clk), .resetn_i(resetn_i),
        .EX_MEM_give_i(EX_MEM_give_i), .MEM_EX_get_o(MEM_EX_get_o),
        .EX_MEM_instruction_i(EX_MEM_instruction_i), .EX_MEM_d_i(EX_MEM_d_i), .EX_MEM_rs2_i(EX_MEM_rs2_i),
        .WB_MEM_get_i(WB_MEM_get_i), .MEM_WB_give_o(MEM_WB_give_o),
        .MEM_WB_instruction_o(MEM_WB_instruction_o), .MEM_WB_d_o(MEM_WB_d_o),
        .MEM_WB_misaligned_o(MEM_WB_misaligned_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_be_o(mem_be_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    typedef struct { logic [31:0] ins; logic [31:0] d; logic mis; int acc; int lat; } wb_exp_t;
    typedef struct { logic we; logic [31:0] addr; logic [3:0] be; logic [31:0] wdata; } bus_exp_t;

    wb_exp_t     wb_q[$];
    bus_exp_t    bus_q[$];
    int          vec = 0, err = 0, cyc = 0;
    int          gnt_dly = 0, rv_dly = 0, wb_stall = 0;
    logic [31:0] rdata_v = 32'h0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Bus responder: checks request fields and their stability, grants, returns read data
    initial begin : bus_model
        int bst, bcnt, rcnt;
        logic have, stable;
        logic [68:0] snap;
        bus_exp_t e;
        bst = 0; bcnt = 0; rcnt = 0; have = 1'b0; stable = 1'b1; snap = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = 32'h0;
            if (!resetn_i) begin
                bst = 0;
            end else if (mem_req_o) begin
                if (bst == 0) begin
                    snap = {mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o};
                    stable = 1'b1; bcnt = 0; bst = 1;
                    have = (bus_q.size() != 0);
                    if (have) begin
                        e = bus_q.pop_front();
                        chk("bus_req", 160'(snap), 160'({e.we, e.addr, e.be, e.wdata}));
                    end else begin
                        vec++; err++;
                        $display("FAIL unexpected_req: got request addr %0h, expected no request", mem_addr_o);
                    end
                end else if ({mem_we_o, mem_addr_o, mem_be_o, mem_wdata_o} != snap || MEM_EX_get_o) begin
                    stable = 1'b0;
                end
                if (bcnt >= gnt_dly) begin
                    // Stray rvalid alongside gnt must be ignored by the DUT
                    mem_gnt_i = 1'b1; mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5A5A5A5A;
                    if (have) chk("bus_stable", 160'(stable), 160'(1));
                    bst = mem_we_o ? 0 : 2;
                    rcnt = 0;
                end
                bcnt++;
            end else if (bst == 2) begin
                if (rcnt >= rv_dly) begin
                    mem_rvalid_i = 1'b1; mem_rdata_i = rdata_v; bst = 0;
                end
                rcnt++;
            end
        end
    end

    // WB side: applies backpressure and scores each delivered result
    initial begin : wb_monitor
        int wst, wcnt, first;
        logic [64:0] wsnap;
        logic wstable;
        wb_exp_t x;
        wst = 0; wcnt = 0; first = 0; wsnap = '0; wstable = 1'b1;
        WB_MEM_get_i = 1'b0;
        forever begin
            @(negedge clk);
            WB_MEM_get_i = 1'b0;
            if (!resetn_i) begin
                wst = 0;
            end else if (MEM_WB_give_o) begin
                if (wst == 0) begin
                    wsnap = {MEM_WB_misaligned_o, MEM_WB_instruction_o, MEM_WB_d_o};
                    wstable = 1'b1; first = cyc; wcnt = 0; wst = 1;
                end else if ({MEM_WB_misaligned_o, MEM_WB_instruction_o, MEM_WB_d_o} != wsnap) begin
                    wstable = 1'b0;
                end
                if (MEM_EX_get_o) wstable = 1'b0;
                if (wcnt >= wb_stall) begin
                    WB_MEM_get_i = 1'b1; wst = 0;
                    if (wb_q.size() == 0) begin
                        vec++; err++;
                        $display("FAIL unexpected_give: got d %0h, expected no result", MEM_WB_d_o);
                    end else begin
                        x = wb_q.pop_front();
                        chk("wb_instr", 160'(MEM_WB_instruction_o), 160'(x.ins));
                        chk("wb_d", 160'(MEM_WB_d_o), 160'(x.d));
                        chk("wb_misaligned", 160'(MEM_WB_misaligned_o), 160'(x.mis));
                        chk("wb_latency", 160'(first - x.acc), 160'(x.lat));
                        chk("wb_hold_get_low", 160'(wstable), 160'(1));
                    end
                end
                wcnt++;
            end
        end
    end

    task automatic bus_exp(input logic we, input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wd);
        bus_exp_t e;
        e.we = we; e.addr = addr; e.be = be; e.wdata = wd;
        bus_q.push_back(e);
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] d, input logic [31:0] rs2,
                         input logic [31:0] rdata, input int gd, input int rd, input int ws,
                         input logic [31:0] ed, input logic em, input int lat);
        int t;
        wb_exp_t x;
        gnt_dly = gd; rv_dly = rd; rdata_v = rdata; wb_stall = ws;
        EX_MEM_give_i = 1'b1; EX_MEM_instruction_i = ins; EX_MEM_d_i = d; EX_MEM_rs2_i = rs2;
        t = 0;
        while (!MEM_EX_get_o && t < 100) begin @(negedge clk); t++; end
        if (!MEM_EX_get_o) begin
            vec++; err++;
            $display("FAIL accept_timeout: got get=0, expected get=1");
            EX_MEM_give_i = 1'b0;
            return;
        end
        x.ins = ins; x.d = ed; x.mis = em; x.acc = cyc; x.lat = lat;
        wb_q.push_back(x);
        @(posedge clk); #1;
        EX_MEM_give_i = 1'b0; EX_MEM_instruction_i = 32'h0; EX_MEM_d_i = 32'hFFFF_FFFF; EX_MEM_rs2_i = 32'h0;
        t = 0;
        while (wb_q.size() != 0 && t < 100) begin @(negedge clk); t++; end
        if (wb_q.size() != 0) begin
            vec++; err++;
            $display("FAIL wb_timeout: got no result, expected instr %0h", ins);
            wb_q.delete();
        end
        if (bus_q.size() != 0) begin
            vec++; err++;
            $display("FAIL missing_req: got no request, expected addr %0h", bus_q[0].addr);
            bus_q.delete();
        end
        @(negedge clk);
    endtask

    localparam logic [31:0] I_ADDI = 32'h00100093;
    localparam logic [31:0] I_SB   = 32'h00208023;
    localparam logic [31:0] I_SH   = 32'h00209023;
    localparam logic [31:0] I_SW   = 32'h0020A023;
    localparam logic [31:0] I_SBAD = 32'h0020C023;
    localparam logic [31:0] I_LB   = 32'h00008183;
    localparam logic [31:0] I_LH   = 32'h00009183;
    localparam logic [31:0] I_LW   = 32'h0000A183;
    localparam logic [31:0] I_LBAD = 32'h0000B183;
    localparam logic [31:0] I_LBU  = 32'h0000C183;
    localparam logic [31:0] I_LHU  = 32'h0000D183;

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got no completion, expected summary before time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        resetn_i = 1'b0;
        EX_MEM_give_i = 1'b0; EX_MEM_instruction_i = 32'h0; EX_MEM_d_i = 32'h0; EX_MEM_rs2_i = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset_ctl", 160'({MEM_EX_get_o, MEM_WB_give_o, MEM_WB_misaligned_o, mem_req_o, mem_we_o, mem_be_o}), 160'(0));
        chk("reset_dat", 160'({MEM_WB_instruction_o, MEM_WB_d_o, mem_addr_o, mem_wdata_o}), 160'(0));
        resetn_i = 1'b1;
        @(negedge clk);
        chk("get_after_reset", 160'(MEM_EX_get_o), 160'(1));

        //     instr   d             rs2           rdata         gd rd ws  exp_d         mis  lat
        issue(I_ADDI, 32'h0000_1234, 32'h0,        32'h0,        0, 0, 0, 32'h0000_1234, 1'b0, 1);
        bus_exp(1'b1, 32'h100, 4'b1000, 32'hABABABAB);
        issue(I_SB,   32'h0000_0103, 32'h1234_56AB, 32'h0,       2, 0, 0, 32'h0000_0103, 1'b0, 4);
        bus_exp(1'b1, 32'h200, 4'b1100, 32'hCAFECAFE);
        issue(I_SH,   32'h0000_0202, 32'hBEEF_CAFE, 32'h0,       0, 0, 0, 32'h0000_0202, 1'b0, 2);
        bus_exp(1'b1, 32'h300, 4'b1111, 32'h11223344);
        issue(I_SW,   32'h0000_0300, 32'h1122_3344, 32'h0,       0, 0, 0, 32'h0000_0300, 1'b0, 2);
        bus_exp(1'b0, 32'h200, 4'b0100, 32'h0);
        issue(I_LB,   32'h0000_0202, 32'h0,        32'h0080_0000, 0, 0, 0, 32'hFFFF_FF80, 1'b0, 3);
        bus_exp(1'b0, 32'h200, 4'b0100, 32'h0);
        issue(I_LBU,  32'h0000_0202, 32'h0,        32'h0080_0000, 0, 0, 0, 32'h0000_0080, 1'b0, 3);
        bus_exp(1'b0, 32'h204, 4'b1100, 32'h0);
        issue(I_LH,   32'h0000_0206, 32'h0,        32'h8001_0000, 0, 0, 0, 32'hFFFF_8001, 1'b0, 3);
        bus_exp(1'b0, 32'h204, 4'b1100, 32'h0);
        issue(I_LHU,  32'h0000_0206, 32'h0,        32'h8001_0000, 1, 0, 0, 32'h0000_8001, 1'b0, 4);
        bus_exp(1'b0, 32'h400, 4'b1111, 32'h0);
        issue(I_LW,   32'h0000_0400, 32'h0,        32'hDEAD_BEEF, 0, 2, 4, 32'hDEAD_BEEF, 1'b0, 5);
`ifdef MEM_MISALIGN_CHECK_EN
        issue(I_LW,   32'h0000_0301, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 32'h0000_0301, 1'b1, 1);
`else
        bus_exp(1'b0, 32'h300, 4'b1111, 32'h0);
        issue(I_LW,   32'h0000_0301, 32'h0,        32'hCAFE_F00D, 0, 0, 0, 32'hCAFE_F00D, 1'b0, 3);
`endif
        issue(I_LBAD, 32'h0000_0500, 32'h0,        32'h0,        0, 0, 0, 32'h0,         1'b0, 1);
        issue(I_SBAD, 32'h0000_0504, 32'h5555_5555, 32'h0,       0, 0, 0, 32'h0,         1'b0, 1);

        // Reset while a store is stuck waiting for grant
        bus_exp(1'b1, 32'h600, 4'b1111, 32'h01020304);
        gnt_dly = 1000; wb_stall = 0;
        EX_MEM_give_i = 1'b1; EX_MEM_instruction_i = I_SW; EX_MEM_d_i = 32'h600; EX_MEM_rs2_i = 32'h01020304;
        for (int t = 0; t < 100 && !MEM_EX_get_o; t++) @(negedge clk);
        @(posedge clk); #1;
        EX_MEM_give_i = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("req_before_reset", 160'(mem_req_o), 160'(1));
        #2 resetn_i = 1'b0;
        #1 chk("reset_async", 160'({mem_req_o, MEM_WB_give_o, MEM_EX_get_o}), 160'(0));
        gnt_dly = 0;
        bus_q.delete();
        repeat (2) @(negedge clk);
        resetn_i = 1'b1;
        @(negedge clk);
        chk("get_after_midreset", 160'(MEM_EX_get_o), 160'(1));
        issue(I_ADDI, 32'h0000_5678, 32'h0,        32'h0,        0, 0, 0, 32'h0000_5678, 1'b0, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end
endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage between EX and WB. Executes RV32I loads and stores over a single-outstanding request/grant data-memory bus.
- Passes every other instruction's EX result to WB unchanged.
- Uses the same give/get handshake on both sides as the other pipeline stages.

Parameters:
- BITSIZE, 32, datapath width. Only 32 is supported; elaboration error otherwise.

Ports:
- clk  in  1  clock.
- resetn_i  in  1  reset. Asynchronous, active-low.
- EX_MEM_give_i  in  1  EX offers an instruction.
- MEM_EX_get_o  out  1  MEM can accept.
- EX_MEM_instruction_i  in  32  instruction word.
- EX_MEM_d_i  in  BITSIZE  EX result (effective address for load/store).
- EX_MEM_rs2_i  in  BITSIZE  store data.
- WB_MEM_get_i  in  1  WB can accept.
- MEM_WB_give_o  out  1  MEM offers a result.
- MEM_WB_instruction_o  out  32  instruction word.
- MEM_WB_d_o  out  BITSIZE  load data or pass-through result.
- MEM_WB_misaligned_o  out  1  misaligned access flag (see Optional Feature).
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  1 = store.
- mem_addr_o  out  BITSIZE  word-aligned address ({addr[31:2],2'b00}).
- mem_be_o  out  4  byte enables.
- mem_wdata_o  out  BITSIZE  lane-shifted store data.
- mem_gnt_i  in  1  request accepted.
- mem_rvalid_i  in  1  read data valid.
- mem_rdata_i  in  BITSIZE  read data.

Behaviour:
- Handshake: a transfer occurs on a rising edge where give and get are both high. Give, together with its data, is held until that edge.
- All outputs are registered. Reset values: all outputs 0. State GET_INSTR.
- State GET_INSTR:
  - MEM_EX_get_o=1.
  - On transfer, latch instruction, d and rs2.
  - Opcode 0000011 (LOAD) or 0100011 (STORE) -> REQ; anything else -> GIVE.
- State REQ:
  - mem_req_o=1. Address, we, be and wdata stay stable until mem_gnt_i is sampled high.
  - Store: on gnt -> GIVE; MEM_WB_d_o = latched d.
  - Load: on gnt -> WAIT.
- State WAIT:
  - mem_req_o=0.
  - On mem_rvalid_i, select byte/half by addr[1:0], then sign-extend (LB/LH) or zero-extend (LBU/LHU); LW takes the full word. Result is registered into MEM_WB_d_o -> GIVE.
- State GIVE:
  - MEM_WB_give_o=1. Hold until WB_MEM_get_i, then -> GET_INSTR.
- Byte enables:
  - SB: 4'b0001<<addr[1:0].
  - SH: 4'b0011<<addr[1:0].
  - SW: 4'b1111.
- Store data: rs2 replicated across lanes (SB byte x4, SH half x2).
- Invalid funct3 (LOAD 011/110/111, STORE 011-111): no bus request. Instruction goes to GIVE with d = 0.
- Latency (zero-wait bus, WB always ready):
  - Non-memory: 1 cycle, accept -> give.
  - Store: 2 cycles (req cycle with gnt, then give).
  - Load: min 3 cycles, with rvalid no earlier than the cycle after gnt.
- Only one request is outstanding. mem_rvalid_i outside WAIT is ignored.
- An asynchronous reset mid-operation drops mem_req_o and give immediately and discards the latched instruction. The bus tolerates abandoned requests.
- MEM_EX_get_o is low in every state except GET_INSTR (no bypass; one instruction in flight).

Optional Feature:
- Macro MEM_MISALIGN_CHECK_EN.
- When defined:
  - LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0, issue no bus request.
  - Go directly to GIVE with MEM_WB_misaligned_o=1 and MEM_WB_d_o = faulting address.
  - Flag clears on the transfer to WB.
- When undefined:
  - MEM_WB_misaligned_o is tied 0.
  - Misaligned halfword/word accesses use the naturally aligned lanes: be and extraction ignore addr[0] (half) or addr[1:0] (word).

Decomposition:
- Add `LOAD and `STORE opcode macros to instructions.sv.
- New include mem_operations.sv holds the funct3 codes: LB, LH, LW, LBU, LHU, SB, SH, SW.
- State enum local to mem_stage.
- One combinational sub-module, lsu_align: inputs funct3, addr[1:0], rs2, rdata; outputs be, wdata, load result.

Test Plan:
- Non-memory pass-through: ADDI, d=0x0000_1234, WB ready -> give 1 cycle after accept, d=0x1234, no mem_req_o.
- Store byte: SB, addr=0x103, rs2=0xAB, gnt after 2 cycles -> addr=0x100, be=4'b1000, wdata=0xABABABAB, stable until gnt; then give.
- Sign-extending load: LB, addr=0x202, rdata=0x0080_0000 -> d=0xFFFF_FF80. Same with LBU -> 0x0000_0080.
- Backpressure and delay: LW, rdata=0xDEADBEEF with rvalid 3 cycles after gnt, WB_MEM_get_i low 4 cycles -> d held stable, MEM_EX_get_o low throughout.
- Misaligned word: LW, addr=0x301.
  - With MEM_MISALIGN_CHECK_EN: no req, misaligned=1, d=0x301.
  - Without it: addr=0x300, be=4'hF, misaligned=0.
- Reset mid-request: assert resetn_i low while in REQ -> mem_req_o=0 asynchronously. After release, MEM_EX_get_o=1 and the next ADDI passes cleanly.
